// File: rtl/ps2_cmd_decoder.sv
// PS/2 scan-code decoder: maps make/break sequences to game commands and queues new presses.
// Latency: the terminating byte sampled at edge N gives cmd_valid/cmd_code and keys_held after edge N.
// Backpressure: FWFT queue popped on cmd_valid & cmd_ready; when full, new commands are dropped and overflow sticks.
module ps2_cmd_decoder #(
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYC     = 50_000,
  parameter bit REPEAT_SUPPRESS = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  output logic [8:0] keys_held,
  output logic [4:0] fifo_count,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [8:0]     keys_q, keys_d;
  logic [3:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [4:0]     count_q, count_d, cnt_after_pop;
  logic           valid_q, valid_d;
  logic [3:0]     code_q, code_d;
  logic           ovf_q, ovf_d;

  logic           map_hit, map_arrow;
  logic [3:0]     map_code;
  logic           is_make, is_rel, is_ext, key_ok;
  logic           push_req, push, pop, full;

  // Scan-code to command lookup; arrow keys are the only ones legal after E0
  always_comb begin
    map_hit   = 1'b1;
    map_arrow = 1'b0;
    map_code  = 4'd0;
    case (rx_byte)
      8'h6B: begin map_code = 4'd0; map_arrow = 1'b1; end
      8'h1C: map_code = 4'd0;
      8'h74: begin map_code = 4'd1; map_arrow = 1'b1; end
      8'h23: map_code = 4'd1;
      8'h75: begin map_code = 4'd2; map_arrow = 1'b1; end
      8'h1D: map_code = 4'd2;
      8'h72: begin map_code = 4'd3; map_arrow = 1'b1; end
      8'h1B: map_code = 4'd3;
      8'h29: map_code = 4'd4;
      8'h2D: map_code = 4'd5;
      8'h16: map_code = 4'd6;
      8'h1E: map_code = 4'd7;
      8'h26: map_code = 4'd8;
      default: map_hit = 1'b0;
    endcase
  end

  // Prefix FSM next state, terminating-byte classification and prefix timeout
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    is_make = 1'b0;
    is_rel  = 1'b0;
    is_ext  = 1'b0;
    if (rx_valid) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (rx_byte == 8'hE0)      state_d = S_EXT;
          else if (rx_byte == 8'hF0) state_d = S_BRK;
          else if (rx_byte == 8'h00 || rx_byte == 8'hAA || rx_byte == 8'hEE ||
                   rx_byte == 8'hFA || rx_byte == 8'hFC || rx_byte == 8'hFE ||
                   rx_byte == 8'hFF) state_d = S_IDLE;
          else                       is_make = 1'b1;
        end
        S_EXT: begin
          if (rx_byte == 8'hF0)      state_d = S_EXT_BRK;
          else if (rx_byte != 8'hE0) begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          is_rel  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          is_rel  = 1'b1;
          is_ext  = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end else if (state_q != S_IDLE) begin
      // The TIMEOUT_CYC-th consecutive idle edge abandons the prefix
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // Key state tracking and queue push/pop bookkeeping
  always_comb begin
    key_ok   = map_hit && (!is_ext || map_arrow);
    push_req = is_make && key_ok && (!keys_q[map_code] || !REPEAT_SUPPRESS);
    keys_d   = keys_q;
    if (is_make && key_ok) keys_d[map_code] = 1'b1;
    if (is_rel && key_ok)  keys_d[map_code] = 1'b0;

    pop     = valid_q && cmd_ready;
    full    = (count_q == 5'(FIFO_DEPTH));
    push    = push_req && (!full || pop);
    ovf_d   = ovf_q || (push_req && full && !pop);
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q + 5'(push) - 5'(pop);
    valid_d = (count_d != 5'd0);

    // Next head: the incoming command if the queue drains to it, else the entry at the new read pointer
    cnt_after_pop = count_q - 5'(pop);
    code_d        = code_q;
    if (cnt_after_pop == 5'd0) begin
      if (push) code_d = map_code;
    end else begin
      code_d = mem_q[rd_d];
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      keys_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      keys_q  <= keys_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  // Queue storage; contents are only meaningful under the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= map_code;
  end

  assign cmd_valid  = valid_q;
  assign cmd_code   = code_q;
  assign keys_held  = keys_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Directed bench for ps2_cmd_decoder: decode, repeat suppression, queue full/overflow,
// prefix timeout and reset mid-sequence, checked with immediate assertions.
module tb_ps2_cmd_decoder;

  localparam int T = 20;

  logic       clk;
  logic       reset_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic [8:0] keys_held;
  logic [4:0] fifo_count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  ps2_cmd_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYC(T), .REPEAT_SUPPRESS(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .keys_held  (keys_held),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte strobe; returns at the negedge after the sampling edge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pop1();
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic fill_four();
    send(8'h16); send(8'hF0); send(8'h16);
    send(8'h1E); send(8'hF0); send(8'h1E);
    send(8'h26); send(8'hF0); send(8'h26);
    send(8'h29); send(8'hF0); send(8'h29);
  endtask

  initial begin
    logic [3:0] exp_a [4];
    logic [3:0] exp_b [4];
    exp_a = '{4'd6, 4'd7, 4'd8, 4'd4};
    exp_b = '{4'd7, 4'd8, 4'd4, 4'd5};

    reset_n   = 1'b0;
    rx_byte   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
    #12;
    chk("rst_valid", 9'(cmd_valid), 9'd0);
    chk("rst_code",  9'(cmd_code),  9'd0);
    chk("rst_keys",  keys_held,     9'd0);
    chk("rst_count", 9'(fifo_count), 9'd0);
    chk("rst_ovf",   9'(overflow),  9'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Plain make/release with consumer ready
    cmd_ready = 1'b1;
    send(8'h1C);
    chk("lr_valid", 9'(cmd_valid), 9'd1);
    chk("lr_code",  9'(cmd_code),  9'd0);
    chk("lr_keys",  keys_held,     9'b000000001);
    chk("lr_count", 9'(fifo_count), 9'd1);
    @(negedge clk);
    chk("lr_popped", 9'(fifo_count), 9'd0);
    cmd_ready = 1'b0;
    send(8'hF0); send(8'h1C);
    chk("lr_keys_rel", keys_held, 9'd0);
    chk("lr_count_rel", 9'(fifo_count), 9'd0);

    // Extended auto-repeat suppressed
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h75); send(8'hE0); send(8'h75);
    chk("rep_count", 9'(fifo_count), 9'd1);
    chk("rep_code",  9'(cmd_code),  9'd2);
    chk("rep_keys",  keys_held,     9'b000000100);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("rep_keys_rel", keys_held, 9'd0);
    pop1();
    chk("rep_drained", 9'(cmd_valid), 9'd0);
    send(8'hF0); send(8'h29);
    chk("rel_unheld_keys",  keys_held, 9'd0);
    chk("rel_unheld_count", 9'(fifo_count), 9'd0);

    // Fill queue, then overflow drops the fifth command
    fill_four();
    chk("full_count", 9'(fifo_count), 9'd4);
    chk("full_ovf",   9'(overflow),  9'd0);
    send(8'h2D);
    chk("ovf_count", 9'(fifo_count), 9'd4);
    chk("ovf_flag",  9'(overflow),  9'd1);
    chk("ovf_head",  9'(cmd_code),  9'd6);
    send(8'hF0); send(8'h2D);
    for (int i = 0; i < 4; i++) begin
      chk("drain_a", 9'(cmd_code), 9'(exp_a[i]));
      pop1();
    end
    chk("drain_a_empty", 9'(fifo_count), 9'd0);
    chk("ovf_sticky",    9'(overflow),  9'd1);

    // Asynchronous reset clears state without a clock edge
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ovf",   9'(overflow),  9'd0);
    chk("arst_valid", 9'(cmd_valid), 9'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Push and pop on the same edge while full
    fill_four();
    @(negedge clk);
    rx_byte   = 8'h2D;
    rx_valid  = 1'b1;
    cmd_ready = 1'b1;
    @(negedge clk);
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
    chk("pp_count", 9'(fifo_count), 9'd4);
    chk("pp_ovf",   9'(overflow),  9'd0);
    chk("pp_head",  9'(cmd_code),  9'd7);
    chk("pp_keys",  keys_held,     9'b000100000);
    for (int i = 0; i < 4; i++) begin
      chk("drain_b", 9'(cmd_code), 9'(exp_b[i]));
      pop1();
    end
    chk("drain_b_empty", 9'(fifo_count), 9'd0);
    send(8'hF0); send(8'h2D);

    // Prefix still pending one cycle short of the timeout: E0 29 is ignored
    send(8'hE0);
    repeat (T - 2) @(negedge clk);
    send(8'h29);
    chk("pre_tmo_count", 9'(fifo_count), 9'd0);
    chk("pre_tmo_keys",  keys_held,     9'd0);
    // Prefix abandoned after the timeout: 29 decodes as PLACE
    send(8'hE0);
    repeat (T - 1) @(negedge clk);
    send(8'h29);
    chk("tmo_count", 9'(fifo_count), 9'd1);
    chk("tmo_code",  9'(cmd_code),  9'd4);
    chk("tmo_keys",  keys_held,     9'b000010000);
    send(8'hF0); send(8'h29);
    pop1();
    send(8'hE0); send(8'h12);
    chk("e0_12_count", 9'(fifo_count), 9'd0);
    send(8'hFA); send(8'hAA);
    chk("ign_count", 9'(fifo_count), 9'd0);
    send(8'hE0); send(8'hE0); send(8'h72);
    chk("e0e0_code",  9'(cmd_code),  9'd3);
    chk("e0e0_count", 9'(fifo_count), 9'd1);
    send(8'hE0); send(8'hF0); send(8'h72);
    pop1();
    send(8'hE0); send(8'h6B);
    chk("ext_left_code",  9'(cmd_code),  9'd0);
    chk("ext_left_valid", 9'(cmd_valid), 9'd1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    pop1();
    chk("ext_left_keys", keys_held, 9'd0);

    // Reset discards a pending E0 F0 prefix
    send(8'hE0); send(8'hF0);
    pulse_reset();
    send(8'h23);
    chk("rstseq_count", 9'(fifo_count), 9'd1);
    chk("rstseq_code",  9'(cmd_code),  9'd1);
    chk("rstseq_keys",  keys_held,     9'b000000010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
